bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 129 ++++++++++++
 tb/tb_bus_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with per-grant watchdog.
// One owner at a time, one idle cycle between consecutive grants.
module bus_arbiter #(
    parameter int unsigned N_MASTER = 16,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_MASTER-1:0] request,
    input  logic                done,
    output logic [N_MASTER-1:0] grant,
    output logic [3:0]          grant_id,
    output logic                busy,
    output logic                timeout_err
);

    localparam int unsigned WDW = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [N_MASTER-1:0] grant_q, grant_d;
    logic [3:0]          gid_q, gid_d;
    logic [3:0]          ptr_q, ptr_d;
    logic [WDW-1:0]      wd_q, wd_d;
    logic                terr_q, terr_d;

    logic [15:0]         req16;
    logic [15:0]         oh;
    logic                pick_vld;
    logic [3:0]          pick_id;
    logic [4:0]          sum;
    logic                rel_done;
    logic                rel_wdraw;
    logic                expire;

    assign req16 = 16'(request);

    // Rotating search starting at ptr, first set request wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = 4'd0;
        sum      = 5'd0;
        for (int i = 0; i < int'(N_MASTER); i++) begin
            sum = {1'b0, ptr_q} + 5'(i);
            if (sum >= 5'(N_MASTER)) begin
                sum = sum - 5'(N_MASTER);
            end
            if (!pick_vld && req16[sum[3:0]]) begin
                pick_vld = 1'b1;
                pick_id  = sum[3:0];
            end
        end
    end

    assign oh        = 16'd1 << pick_id;
    assign rel_done  = done;
    assign rel_wdraw = ~req16[gid_q];
    assign expire    = (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        terr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = OWNED;
                    grant_d = oh[N_MASTER-1:0];
                    gid_d   = pick_id;
                    wd_d    = '0;
                    if (pick_id == 4'(N_MASTER - 1)) begin
                        ptr_d = 4'd0;
                    end else begin
                        ptr_d = pick_id + 4'd1;
                    end
                end
            end
            OWNED: begin
                if (rel_done || rel_wdraw || expire) begin
                    state_d = IDLE;
                    grant_d = '0;
                    gid_d   = 4'd0;
                    wd_d    = '0;
                    // Watchdog only flags when nothing else released the bus.
                    terr_d  = expire && !rel_done && !rel_wdraw;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                gid_d   = 4'd0;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gid_q   <= 4'd0;
            ptr_q   <= 4'd0;
            wd_q    <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            terr_q  <= terr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = gid_q;
    assign busy        = (state_q == OWNED);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter against an owner/ptr
// reference model that advances once per clock edge.
module tb_bus_arbiter;

    localparam int N  = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  request;
    logic          done;
    logic [N-1:0]  grant;
    logic [3:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    logic m_terr  = 1'b0;

    logic [15:0] seq[$];
    logic [15:0] exp_seq[6];
    logic        prev_busy;

    bus_arbiter #(.N_MASTER(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .done        (done),
        .grant       (grant),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: which master owns the bus and for how many cycles.
    task automatic model_edge();
        int   m;
        logic req_own;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_terr  = 1'b0;
        end else if (m_owner < 0) begin
            m_terr = 1'b0;
            for (int k = 0; k < N; k++) begin
                m = (m_ptr + k) % N;
                if (m_owner < 0 && ((request >> m) & 1) == 1) begin
                    m_owner = m;
                    m_ptr   = (m + 1) % N;
                    m_held  = 1;
                end
            end
        end else begin
            req_own = ((request >> m_owner) & 1) == 1;
            if (done || !req_own || m_held == TO) begin
                m_terr  = (m_held == TO) && !done && req_own;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_terr = 1'b0;
                m_held++;
            end
        end
    endtask

    task automatic tick();
        logic [15:0] eg;
        @(posedge clk);
        model_edge();
        #1;
        eg = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        request = '0;
        done    = 1'b0;
        tick();
        tick();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_gid", 32'(grant_id), 32'h0);
        rst = 1'b0;

        // Single requester, release by done, regrant after dead cycle
        request = 16'h0004;
        tick();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_gid", 32'(grant_id), 32'h2);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("single_drop", 32'(grant), 32'h0);
        tick();
        chk("single_regrant", 32'(grant), 32'h4);
        request = '0;
        tick();
        tick();

        // Round-robin over masters 0, 3, 15
        do_reset();
        request   = 16'h8009;
        prev_busy = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy && !prev_busy) seq.push_back(grant);
            prev_busy = busy;
            done = (m_owner >= 0 && m_held == 4);
        end
        done = 1'b0;
        exp_seq = '{16'h0001, 16'h0008, 16'h8000,
                    16'h0001, 16'h0008, 16'h8000};
        chk("rr_count", 32'(seq.size() >= 6), 32'h1);
        for (int i = 0; i < 6 && i < seq.size(); i++) begin
            chk("rr_seq", 32'(seq[i]), 32'(exp_seq[i]));
        end

        // Wrap-around after master 15
        do_reset();
        request = 16'h8000;
        tick();
        chk("wrap_m15", 32'(grant), 32'h8000);
        done = 1'b1;
        tick();
        done    = 1'b0;
        request = 16'h8001;
        tick();
        chk("wrap_m0", 32'(grant), 32'h0001);

        // Withdrawal
        do_reset();
        request = 16'h0020;
        tick();
        tick();
        request = '0;
        tick();
        chk("wdraw_grant", 32'(grant), 32'h0);
        chk("wdraw_terr", 32'(timeout_err), 32'h0);

        // Watchdog expiry, then done coinciding with expiry
        do_reset();
        request = 16'h0008;
        tick();
        for (int c = 0; c < TO; c++) begin
            chk("wd_hold", 32'(grant), 32'h8);
            tick();
        end
        chk("wd_drop", 32'(grant), 32'h0);
        chk("wd_terr", 32'(timeout_err), 32'h1);
        tick();
        chk("wd_terr_pulse", 32'(timeout_err), 32'h0);
        chk("wd_regrant", 32'(grant), 32'h8);
        for (int c = 1; c < TO; c++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("wd_done_drop", 32'(grant), 32'h0);
        chk("wd_done_terr", 32'(timeout_err), 32'h0);

        // Reset mid-grant
        do_reset();
        request = 16'h0080;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_grant", 32'(grant), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_terr", 32'(timeout_err), 32'h0);
        rst     = 1'b0;
        request = 16'h0081;
        tick();
        chk("rstmid_first", 32'(grant), 32'h0001);

        // Random traffic
        request = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) request = N'($urandom);
            if ($urandom_range(0, 7) == 0) request = '0;
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            tick();
            chk("onehot", 32'($countones(grant) <= 1), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
